// File: rtl/fetch_align_ctrl.sv
// rtl/fetch_align_ctrl.sv - RV32IC fetch sequencer and 16/32-bit instruction realigner
//
// Purpose: owns the fetch PC, drives word reads to a 1-cycle-latency imem and
// turns the returned words into one instruction per cycle for decode, including
// 32-bit instructions that straddle a word boundary.
//
// Configuration macro: RVC_ALIGN_EN
//   defined   - compressed (16-bit) instructions and halfword-aligned PCs supported
//   undefined - every instruction is 32-bit and word aligned; instr_comp tied 0
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   stall          decode cannot accept; fetch state and outputs are frozen
//   jmp, jmp_pc    redirect to jmp_pc (wins over stall), bit0 ignored
//   mem_addr       word address to imem (bits[1:0]=0)
//   mem_rdata      imem data for last cycle's mem_addr
//   instr          instruction (compressed in [15:0], upper half zero)
//   instr_pc       PC of instr
//   instr_comp     instr is a 16-bit instruction
//   valid          instr/instr_pc/instr_comp meaningful this cycle
module fetch_align_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jmp,
  input  logic [31:0] jmp_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_comp,
  output logic        valid
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_LO    = 2'd1;  // instruction starts at mem_rdata[15:0]
`ifdef RVC_ALIGN_EN
  localparam logic [1:0] S_HI    = 2'd2;  // instruction starts at mem_rdata[31:16]
  localparam logic [1:0] S_SPLIT = 2'd3;  // upper half of a straddling 32-bit instr
  localparam logic [31:0] BOOT_PC    = {RESET_PC[31:1], 1'b0};
  localparam logic [1:0]  BOOT_STATE = BOOT_PC[1] ? S_HI : S_LO;
`else
  localparam logic [31:0] BOOT_PC    = {RESET_PC[31:2], 2'b00};
  localparam logic [1:0]  BOOT_STATE = S_LO;
`endif
  localparam logic [31:0] BOOT_WORD = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state, state_nxt, adv_state, jmp_state;
  logic [31:0] pc, pc_nxt, adv_pc, jmp_target;
  logic [31:0] cur_addr, adv_addr;
  logic        emit;
  logic [31:0] emit_instr;

`ifdef RVC_ALIGN_EN
  logic [15:0] hbuf;
  logic        hbuf_ld;
  logic        emit_comp;
  logic        unused_jmp_bits;

  function automatic logic is_comp(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  assign jmp_target      = {jmp_pc[31:1], 1'b0};
  assign jmp_state       = jmp_pc[1] ? S_HI : S_LO;
  assign unused_jmp_bits = jmp_pc[0];
`else
  logic        unused_jmp_bits;

  assign jmp_target      = {jmp_pc[31:2], 2'b00};
  assign jmp_state       = S_LO;
  assign unused_jmp_bits = ^jmp_pc[1:0];
`endif

  // What each state does when free to advance (no jmp, no stall).
  always_comb begin
    adv_state  = state;
    adv_pc     = pc;
    adv_addr   = cur_addr;
    emit       = 1'b0;
    emit_instr = 32'h0;
`ifdef RVC_ALIGN_EN
    emit_comp  = 1'b0;
    hbuf_ld    = 1'b0;
`endif
    case (state)
      S_BOOT: begin
        adv_state = BOOT_STATE;
        adv_pc    = BOOT_PC;
        adv_addr  = BOOT_WORD;
      end
      S_LO: begin
        emit = 1'b1;
`ifdef RVC_ALIGN_EN
        if (is_comp(mem_rdata[15:0])) begin
          // Upper half of this word still holds the next instruction: re-read it.
          emit_instr = {16'h0, mem_rdata[15:0]};
          emit_comp  = 1'b1;
          adv_pc     = pc + 32'd2;
          adv_state  = S_HI;
        end else
`endif
        begin
          emit_instr = mem_rdata;
          adv_pc     = pc + 32'd4;
          adv_addr   = cur_addr + 32'd4;
        end
      end
`ifdef RVC_ALIGN_EN
      S_HI: begin
        adv_addr = cur_addr + 32'd4;
        if (is_comp(mem_rdata[31:16])) begin
          emit       = 1'b1;
          emit_instr = {16'h0, mem_rdata[31:16]};
          emit_comp  = 1'b1;
          adv_pc     = pc + 32'd2;
          adv_state  = S_LO;
        end else begin
          // Straddling 32-bit instruction: park the low half, fetch the rest.
          hbuf_ld   = 1'b1;
          adv_state = S_SPLIT;
        end
      end
      S_SPLIT: begin
        emit       = 1'b1;
        emit_instr = {mem_rdata[15:0], hbuf};
        adv_pc     = pc + 32'd4;
        adv_state  = S_HI;  // the word just read continues at its upper half
      end
`endif
      default: begin
        adv_state = S_BOOT;
      end
    endcase
  end

  // Redirect beats stall beats advance. A stall re-reads cur_addr so that
  // mem_rdata, and with it every output, is identical next cycle.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    mem_addr  = cur_addr;
    if (jmp) begin
      state_nxt = jmp_state;
      pc_nxt    = jmp_target;
      mem_addr  = {jmp_pc[31:2], 2'b00};
    end else if (!stall) begin
      state_nxt = adv_state;
      pc_nxt    = adv_pc;
      mem_addr  = adv_addr;
    end
  end

  // cur_addr resets to the boot word so a stall in BOOT keeps reading it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_BOOT;
      pc       <= BOOT_PC;
      cur_addr <= BOOT_WORD;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      cur_addr <= mem_addr;
    end
  end

`ifdef RVC_ALIGN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hbuf <= 16'h0;
    end else if (!jmp && !stall && hbuf_ld) begin
      hbuf <= mem_rdata[31:16];
    end
  end
`endif

  assign valid    = emit & ~jmp & ~reset;
  assign instr    = valid ? emit_instr : 32'h0;
  assign instr_pc = valid ? pc : 32'h0;
`ifdef RVC_ALIGN_EN
  assign instr_comp = valid & emit_comp;
`else
  assign instr_comp = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// tb/tb_fetch_align_ctrl.sv - scoreboard bench for fetch_align_ctrl against an instruction-stream model
module tb_fetch_align_ctrl;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
`ifdef RVC_ALIGN_EN
  localparam bit          RVC        = 1'b1;
  localparam logic [31:0] TB_BOOT_PC = {TB_RESET_PC[31:1], 1'b0};
`else
  localparam bit          RVC        = 1'b0;
  localparam logic [31:0] TB_BOOT_PC = {TB_RESET_PC[31:2], 2'b00};
`endif
  localparam logic [31:0] TB_BOOT_WORD = {TB_RESET_PC[31:2], 2'b00};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_pc = 32'h0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_comp;
  logic        valid;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_ovr [logic [31:0]];
  logic [31:0] model_pc;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] prev_addr = 32'h0;
  bit          prev_reset = 1'b1;
  bit          in_boot = 1'b1;
  bit          bubble_done = 1'b0;

  fetch_align_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .jmp       (jmp),
    .jmp_pc    (jmp_pc),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .instr     (instr),
    .instr_pc  (instr_pc),
    .instr_comp(instr_comp),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash32(input logic [31:0] a);
    logic [31:0] x;
    x = a ^ (a >> 15);
    x = x * 32'h2C1B_3C6D;
    x = x ^ (x >> 12);
    x = x * 32'h297A_2D39;
    x = x ^ (x >> 15);
    return x;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_ovr.exists(w)) return mem_ovr[w];
    return hash32(w);
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_read(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // imem: synchronous, one cycle read latency
  always @(posedge clk) mem_rdata <= mem_read(mem_addr);

  // Reference: the program as a stream of instructions starting at model_pc.
  task automatic push_next();
    exp_t e;
    logic [15:0] h0;
    if (RVC) begin
      h0 = half_at(model_pc);
      if (h0[1:0] != 2'b11) begin
        e = '{instr: {16'h0, h0}, pc: model_pc, comp: 1'b1};
        model_pc = model_pc + 32'd2;
      end else begin
        e = '{instr: {half_at(model_pc + 32'd2), h0}, pc: model_pc, comp: 1'b0};
        model_pc = model_pc + 32'd4;
      end
    end else begin
      e = '{instr: mem_read(model_pc), pc: model_pc, comp: 1'b0};
      model_pc = model_pc + 32'd4;
    end
    exp_q.push_back(e);
  endtask

  task automatic topup();
    while (exp_q.size() < 4) push_next();
  endtask

  task automatic flush_to(input logic [31:0] p);
    exp_q.delete();
    model_pc = p;
    topup();
  endtask

  task automatic step(input logic r, input logic j, input logic [31:0] jp, input logic s);
    @(posedge clk);
    #1;
    reset  = r;
    jmp    = j;
    jmp_pc = jp;
    stall  = s;
    if (r) flush_to(TB_BOOT_PC);
    else if (j) flush_to(RVC ? {jp[31:1], 1'b0} : {jp[31:2], 2'b00});
    else topup();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, half a cycle after inputs change.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_valid", {31'b0, valid}, 32'd0);
        in_boot     = 1'b1;
        bubble_done = 1'b0;
      end else if (jmp) begin
        check("jmp_valid", {31'b0, valid}, 32'd0);
        check("jmp_addr", mem_addr, {jmp_pc[31:2], 2'b00});
        in_boot     = 1'b0;
        bubble_done = 1'b0;
      end else if (in_boot) begin
        check("boot_valid", {31'b0, valid}, 32'd0);
        check("boot_addr", mem_addr, TB_BOOT_WORD);
        if (!stall) in_boot = 1'b0;
      end else if (exp_q.size() == 0) begin
        check("queue_nonempty", 32'd0, 32'd1);
      end else begin
        if (!exp_q[0].comp && exp_q[0].pc[1] && !bubble_done) begin
          check("split_bubble", {31'b0, valid}, 32'd0);
          if (!stall) bubble_done = 1'b1;
        end else begin
          check("valid", {31'b0, valid}, 32'd1);
          check("instr", instr, exp_q[0].instr);
          check("instr_pc", instr_pc, exp_q[0].pc);
          check("instr_comp", {31'b0, instr_comp}, {31'b0, exp_q[0].comp});
          if (!stall) begin
            void'(exp_q.pop_front());
            bubble_done = 1'b0;
          end
        end
        if (stall && !prev_reset) check("stall_addr", mem_addr, prev_addr);
      end
      if (valid !== 1'b1) begin
        check("idle_zero", instr | instr_pc | {31'b0, instr_comp}, 32'd0);
      end
      prev_addr  = mem_addr;
      prev_reset = reset;
    end
  end

  initial begin
    int          r;
    logic [31:0] tgt;
    flush_to(TB_BOOT_PC);

    // single 32-bit word at reset
    step(1, 0, 0, 0);
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h0000_0013;
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);

    // two compressed instructions in one word
    step(1, 0, 0, 0);
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h4501_4081;
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);

    // compressed then straddling 32-bit, reset landing in the SPLIT cycle
    step(1, 0, 0, 0);
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h0013_4081;
    mem_ovr[32'h4] = 32'h1234_0000;
    mem_ovr[32'h104] = 32'h4501_0001;
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // redirect to a halfword target, then stall at 0x10
    step(0, 1, 32'h0000_0106, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0010, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);

    // jmp together with stall: jmp wins
    step(0, 1, 32'h0000_0200, 1);
    repeat (4) step(0, 0, 0, 0);

    // address wrap-around
    step(0, 1, 32'hFFFF_FFFA, 0);
    repeat (10) step(0, 0, 0, 0);

    // randomized traffic
    mem_ovr.delete();
    step(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r   = $urandom_range(0, 99);
      tgt = {($urandom_range(0, 1) == 1) ? 20'hFFFFF : 20'h00000, 12'($urandom_range(0, 4095))};
      if (r < 2)       step(1, 0, 0, 0);
      else if (r < 8)  step(0, 1, tgt, 1'($urandom_range(0, 1)));
      else if (r < 25) step(0, 0, 0, 1);
      else             step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
